// File: rtl/battleship_turn_sequencer_if.sv
// ============================================================================
// Module      : battleship_turn_sequencer_if
// Description : Button/datapath-side signal bundle of the battleship turn
//               sequencer; master drives the event pulses, slave is the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface battleship_turn_sequencer_if #(
    parameter int NUM_SHIPS = 5
);
    localparam int c_CW = $clog2(NUM_SHIPS * (NUM_SHIPS + 1) / 2 + 1);

    logic            start;
    logic            place_confirm;
    logic            fire_valid;
    logic            fire_hit;
    logic            pc_shot_valid;
    logic            pc_shot_hit;
    logic            colocation_ships_State;
    logic            player_turn_State;
    logic            pc_turn_State;
    logic            pc_fire_req;
    logic [2:0]      player_ships_input_internal;
    logic [4:0]      turn_seconds_left;
    logic [c_CW-1:0] player_hits;
    logic [c_CW-1:0] pc_hits;
    logic            game_over;
    logic            player_won;

    modport master (
        output start, place_confirm, fire_valid, fire_hit, pc_shot_valid, pc_shot_hit,
        input  colocation_ships_State, player_turn_State, pc_turn_State, pc_fire_req,
        input  player_ships_input_internal, turn_seconds_left, player_hits, pc_hits,
        input  game_over, player_won
    );

    modport slave (
        input  start, place_confirm, fire_valid, fire_hit, pc_shot_valid, pc_shot_hit,
        output colocation_ships_State, player_turn_State, pc_turn_State, pc_fire_req,
        output player_ships_input_internal, turn_seconds_left, player_hits, pc_hits,
        output game_over, player_won
    );
endinterface

`default_nettype wire

// File: rtl/battleship_turn_sequencer.sv
// ============================================================================
// Module      : battleship_turn_sequencer
// Description : Game-phase controller: ship placement, alternating player/PC
//               turns with countdown, hit tracking and winner decision.
//               Optional macro TURN_TIMEOUT_EN: an expired player timer
//               forfeits the turn to the PC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module battleship_turn_sequencer #(
    parameter int NUM_SHIPS     = 5,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TURN_SECONDS  = 15,
    parameter int PC_DELAY      = 25_000_000
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    battleship_turn_sequencer_if.slave   bus
);
    localparam int CW = $clog2(NUM_SHIPS * (NUM_SHIPS + 1) / 2 + 1);
    localparam int TW = $clog2(TICKS_PER_SEC + 1);
    localparam int DW = $clog2(PC_DELAY + 1);
    localparam logic [CW-1:0] c_TOTAL      = CW'(NUM_SHIPS * (NUM_SHIPS + 1) / 2);
    localparam logic [TW-1:0] c_TICK_LAST  = TW'(TICKS_PER_SEC - 1);
    localparam logic [DW-1:0] c_DELAY_LAST = DW'(PC_DELAY - 1);
    localparam logic [2:0]    c_LAST_SHIP  = 3'(NUM_SHIPS);
    localparam logic [4:0]    c_SECS       = 5'(TURN_SECONDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PLACE  = 3'd1,
        S_PLAYER = 3'd2,
        S_PC     = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_size, w_size_nxt;
    logic [4:0]      r_secs, w_secs_nxt;
    logic [TW-1:0]   r_tick, w_tick_nxt;
    logic [DW-1:0]   r_delay, w_delay_nxt;
    logic            r_armed, w_armed_nxt;
    logic            r_fire_req, w_fire_req_nxt;
    logic [CW-1:0]   r_player_hits, w_player_hits_nxt;
    logic [CW-1:0]   r_pc_hits, w_pc_hits_nxt;
    logic            r_won, w_won_nxt;
    logic            r_place, r_player, r_pc, r_over;
    logic [CW-1:0]   w_player_inc, w_pc_inc;
    logic            w_timeout;

    assign w_player_inc = (r_player_hits == c_TOTAL) ? r_player_hits : r_player_hits + CW'(1);
    assign w_pc_inc     = (r_pc_hits == c_TOTAL) ? r_pc_hits : r_pc_hits + CW'(1);

`ifdef TURN_TIMEOUT_EN
    assign w_timeout = (r_secs == 5'd0);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_size_nxt        = r_size;
        w_secs_nxt        = r_secs;
        w_tick_nxt        = r_tick;
        w_delay_nxt       = r_delay;
        w_armed_nxt       = r_armed;
        w_fire_req_nxt    = 1'b0;
        w_player_hits_nxt = r_player_hits;
        w_pc_hits_nxt     = r_pc_hits;
        w_won_nxt         = r_won;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_PLACE;
                    w_size_nxt  = 3'd1;
                end
            end
            S_PLACE: begin
                if (bus.place_confirm) begin
                    if (r_size == c_LAST_SHIP) begin
                        w_state_nxt = S_PLAYER;
                        w_size_nxt  = 3'd0;
                        w_secs_nxt  = c_SECS;
                        w_tick_nxt  = '0;
                    end else begin
                        w_size_nxt  = r_size + 3'd1;
                    end
                end
            end
            S_PLAYER: begin
                if (r_tick == c_TICK_LAST) begin
                    w_tick_nxt = '0;
                    w_secs_nxt = (r_secs == 5'd0) ? 5'd0 : r_secs - 5'd1;
                end else begin
                    w_tick_nxt = r_tick + TW'(1);
                end
                // A resolved shot takes priority over an expiring timer.
                if (bus.fire_valid) begin
                    if (bus.fire_hit) w_player_hits_nxt = w_player_inc;
                    if (bus.fire_hit && w_player_inc == c_TOTAL) begin
                        w_state_nxt = S_OVER;
                        w_won_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_PC;
                        w_delay_nxt = '0;
                        w_armed_nxt = 1'b0;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_PC;
                    w_delay_nxt = '0;
                    w_armed_nxt = 1'b0;
                end
            end
            S_PC: begin
                // The PC shot is only accepted once the fire request has been issued.
                if (!r_armed) begin
                    if (r_delay == c_DELAY_LAST) begin
                        w_fire_req_nxt = 1'b1;
                        w_armed_nxt    = 1'b1;
                    end else begin
                        w_delay_nxt    = r_delay + DW'(1);
                    end
                end else if (bus.pc_shot_valid) begin
                    if (bus.pc_shot_hit) w_pc_hits_nxt = w_pc_inc;
                    if (bus.pc_shot_hit && w_pc_inc == c_TOTAL) begin
                        w_state_nxt = S_OVER;
                        w_won_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_PLAYER;
                        w_secs_nxt  = c_SECS;
                        w_tick_nxt  = '0;
                    end
                end
            end
            S_OVER: begin
                if (bus.start) begin
                    w_state_nxt       = S_IDLE;
                    w_player_hits_nxt = '0;
                    w_pc_hits_nxt     = '0;
                    w_won_nxt         = 1'b0;
                    w_secs_nxt        = c_SECS;
                    w_tick_nxt        = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_size        <= 3'd0;
            r_secs        <= c_SECS;
            r_tick        <= '0;
            r_delay       <= '0;
            r_armed       <= 1'b0;
            r_fire_req    <= 1'b0;
            r_player_hits <= '0;
            r_pc_hits     <= '0;
            r_won         <= 1'b0;
            r_place       <= 1'b0;
            r_player      <= 1'b0;
            r_pc          <= 1'b0;
            r_over        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_size        <= w_size_nxt;
            r_secs        <= w_secs_nxt;
            r_tick        <= w_tick_nxt;
            r_delay       <= w_delay_nxt;
            r_armed       <= w_armed_nxt;
            r_fire_req    <= w_fire_req_nxt;
            r_player_hits <= w_player_hits_nxt;
            r_pc_hits     <= w_pc_hits_nxt;
            r_won         <= w_won_nxt;
            r_place       <= (w_state_nxt == S_PLACE);
            r_player      <= (w_state_nxt == S_PLAYER);
            r_pc          <= (w_state_nxt == S_PC);
            r_over        <= (w_state_nxt == S_OVER);
        end
    end

    assign bus.colocation_ships_State      = r_place;
    assign bus.player_turn_State           = r_player;
    assign bus.pc_turn_State               = r_pc;
    assign bus.pc_fire_req                 = r_fire_req;
    assign bus.player_ships_input_internal = r_size;
    assign bus.turn_seconds_left           = r_secs;
    assign bus.player_hits                 = r_player_hits;
    assign bus.pc_hits                     = r_pc_hits;
    assign bus.game_over                   = r_over;
    assign bus.player_won                  = r_won;
endmodule

`default_nettype wire

// File: tb/tb_battleship_turn_sequencer.sv
// ============================================================================
// Module      : tb_battleship_turn_sequencer
// Description : Self-checking bench: directed vector table, corner sequences
//               and random play against a cycle-counting game model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_battleship_turn_sequencer;
    localparam int NUM_SHIPS = 3;
    localparam int TICKS     = 10;
    localparam int TURN      = 3;
    localparam int PC_DELAY  = 4;
    localparam int TOTAL     = NUM_SHIPS * (NUM_SHIPS + 1) / 2;
`ifdef TURN_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    battleship_turn_sequencer_if #(.NUM_SHIPS(NUM_SHIPS)) bus ();

    battleship_turn_sequencer #(
        .NUM_SHIPS    (NUM_SHIPS),
        .TICKS_PER_SEC(TICKS),
        .TURN_SECONDS (TURN),
        .PC_DELAY     (PC_DELAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Game model: phase 0 idle, 1 placing, 2 player turn, 3 pc turn, 4 game over.
    int m_phase, m_ship, m_el, m_secs, m_ph, m_ch;
    bit m_req, m_won;

    function automatic logic [19:0] exp_vec(int phase, int ship, int secs, int ph, int ch, bit req, bit won);
        return {phase == 1, phase == 2, phase == 3, req, 3'(ship), 5'(secs), 3'(ph), 3'(ch), phase == 4, won};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {bus.colocation_ships_State, bus.player_turn_State, bus.pc_turn_State, bus.pc_fire_req,
                bus.player_ships_input_internal, bus.turn_seconds_left, bus.player_hits, bus.pc_hits,
                bus.game_over, bus.player_won};
    endfunction

    task automatic check(input string name, input logic [19:0] exp);
        n_cmp++;
        if (dut_vec() !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, dut_vec(), exp, $time);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ship = 0; m_el = 0; m_secs = TURN;
        m_ph = 0; m_ch = 0; m_req = 0; m_won = 0;
    endtask

    task automatic model_step(input bit st, pcf, fv, fh, sv, sh);
        int old_secs;
        int old_el;
        old_secs = m_secs;
        old_el   = m_el;
        m_req    = 0;
        case (m_phase)
            0: if (st) begin m_phase = 1; m_ship = 1; end
            1: if (pcf) begin
                if (m_ship == NUM_SHIPS) begin m_phase = 2; m_ship = 0; m_el = 0; m_secs = TURN; end
                else m_ship++;
            end
            2: begin
                m_el++;
                m_secs = TURN - m_el / TICKS;
                if (m_secs < 0) m_secs = 0;
                if (fv) begin
                    if (fh && m_ph < TOTAL) m_ph++;
                    if (fh && m_ph == TOTAL) begin m_phase = 4; m_won = 1; end
                    else begin m_phase = 3; m_el = 0; end
                end else if (TIMEOUT && old_secs == 0) begin
                    m_phase = 3; m_el = 0;
                end
            end
            3: begin
                if (sv && old_el >= PC_DELAY) begin
                    if (sh && m_ch < TOTAL) m_ch++;
                    if (sh && m_ch == TOTAL) begin m_phase = 4; m_won = 0; end
                    else begin m_phase = 2; m_el = 0; m_secs = TURN; end
                end else begin
                    m_el++;
                    m_req = (m_el == PC_DELAY);
                end
            end
            default: if (st) begin m_phase = 0; m_ph = 0; m_ch = 0; m_won = 0; m_secs = TURN; end
        endcase
    endtask

    task automatic cycle(input bit st, pcf, fv, fh, sv, sh);
        bus.start = st; bus.place_confirm = pcf; bus.fire_valid = fv;
        bus.fire_hit = fh; bus.pc_shot_valid = sv; bus.pc_shot_hit = sh;
        @(posedge clk);
        #1;
        model_step(st, pcf, fv, fh, sv, sh);
        bus.start = 0; bus.place_confirm = 0; bus.fire_valid = 0;
        bus.fire_hit = 0; bus.pc_shot_valid = 0; bus.pc_shot_hit = 0;
        check("model", exp_vec(m_phase, m_ship, m_secs, m_ph, m_ch, m_req, m_won));
    endtask

    task automatic do_reset(input int n);
        rst = 1;
        bus.start = 0; bus.place_confirm = 0; bus.fire_valid = 0;
        bus.fire_hit = 0; bus.pc_shot_valid = 0; bus.pc_shot_hit = 0;
        repeat (n) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        check("reset", exp_vec(0, 0, TURN, 0, 0, 0, 0));
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (bus.pc_fire_req !== 1'b1 && n < 20) begin
            cycle(0, 0, 0, 0, 0, 0);
            n++;
        end
        if (n == 20) check_val({name, "_req_timeout"}, 0, 1);
    endtask

    typedef struct {
        bit st, pcf, fv, fh, sv, sh;
        int phase, ship, secs, ph, ch;
        bit req;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //        st pc fv fh sv sh  ph sz sec pH pC req
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 0, 0, 2, 0, 3, 0, 0, 0};
        tbl[4]  = '{0, 0, 1, 1, 0, 0, 3, 0, 3, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 3, 0, 3, 1, 0, 0};
        tbl[6]  = '{0, 0, 1, 1, 1, 1, 3, 0, 3, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 3, 0, 3, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 3, 0, 3, 1, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 3, 0, 3, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 1, 1, 2, 0, 3, 1, 1, 0};
        tbl[11] = '{1, 1, 0, 0, 1, 1, 2, 0, 3, 1, 1, 0};

        do_reset(2);
        foreach (tbl[i]) begin
            cycle(tbl[i].st, tbl[i].pcf, tbl[i].fv, tbl[i].fh, tbl[i].sv, tbl[i].sh);
            check($sformatf("table_row%0d", i),
                  exp_vec(tbl[i].phase, tbl[i].ship, tbl[i].secs, tbl[i].ph, tbl[i].ch, tbl[i].req, 1'b0));
        end

        // Player sinks every remaining cell while the PC keeps missing.
        for (int k = 0; k < 10 && bus.game_over !== 1'b1; k++) begin
            cycle(0, 0, 1, 1, 0, 0);
            if (bus.game_over !== 1'b1) begin
                wait_req("win");
                cycle(0, 0, 0, 0, 1, 0);
            end
        end
        check_val("win_game_over", int'(bus.game_over), 1);
        check_val("win_player_won", int'(bus.player_won), 1);
        check_val("win_player_hits", int'(bus.player_hits), TOTAL);
        cycle(0, 0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 1, 1);
        check_val("over_hits_held", int'(bus.player_hits), TOTAL);
        check_val("over_pc_hits_held", int'(bus.pc_hits), 1);
        cycle(1, 0, 0, 0, 0, 0);
        check_val("restart_hits_cleared", int'(bus.player_hits), 0);

        // Countdown during an idle player turn.
        cycle(1, 0, 0, 0, 0, 0);
        repeat (NUM_SHIPS) cycle(0, 1, 0, 0, 0, 0);
        check_val("timer_start", int'(bus.turn_seconds_left), TURN);
        for (int i = 1; i <= 30; i++) begin
            cycle(0, 0, 0, 0, 0, 0);
            if (i % TICKS == 0)
                check_val($sformatf("timer_after_%0d", i), int'(bus.turn_seconds_left), TURN - i / TICKS);
        end
        cycle(0, 0, 0, 0, 0, 0);
        check_val("timeout_pc_turn", int'(bus.pc_turn_State), TIMEOUT ? 1 : 0);
        check_val("timeout_player_turn", int'(bus.player_turn_State), TIMEOUT ? 0 : 1);
        check_val("timeout_no_hit", int'(bus.player_hits), 0);

        // Reset in the middle of a PC turn.
        if (m_phase == 2) cycle(0, 0, 1, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);
        do_reset(1);
        cycle(1, 0, 0, 0, 0, 0);
        check_val("reset_then_place", int'(bus.colocation_ships_State), 1);
        repeat (PC_DELAY + 4) cycle(0, 0, 0, 0, 0, 0);

        // Random play against the model.
        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 30, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
